// File: rtl/ex_hazard_ctrl_if.sv
// Execute-stage sequencing bus: pipeline status in, stall/kill/select and
// performance counters out.
interface ex_hazard_ctrl_if #(
  parameter int unsigned STALL_CNT_W = 32,
  parameter int unsigned FLUSH_CNT_W = 16
);
  logic                   id_valid;
  logic [4:0]             id_rs1;
  logic [4:0]             id_rs2;
  logic                   id_uses_rs1;
  logic                   id_uses_rs2;
  logic                   ex_valid;
  logic                   ex_is_load;
  logic [4:0]             ex_rd;
  logic                   ex_regWrite;
  logic                   ex_regWriteDouble;
  logic                   ex_mux_sel;
  logic                   ex_annul;
  logic                   mem_ready;
  logic                   perf_clr;
  logic                   if_stall;
  logic                   id_stall;
  logic                   ex_stall;
  logic                   if_kill;
  logic                   id_kill;
  logic                   pc_sel;
  logic [STALL_CNT_W-1:0] stall_cycles;
  logic [FLUSH_CNT_W-1:0] redirect_count;

  // Pipeline side: presents instruction status, consumes control.
  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           ex_valid, ex_is_load, ex_rd, ex_regWrite, ex_regWriteDouble,
           ex_mux_sel, ex_annul, mem_ready, perf_clr,
    input  if_stall, id_stall, ex_stall, if_kill, id_kill, pc_sel,
           stall_cycles, redirect_count
  );

  // Controller side.
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           ex_valid, ex_is_load, ex_rd, ex_regWrite, ex_regWriteDouble,
           ex_mux_sel, ex_annul, mem_ready, perf_clr,
    output if_stall, id_stall, ex_stall, if_kill, id_kill, pc_sel,
           stall_cycles, redirect_count
  );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage pipeline sequencing: load-use interlock, branch redirect with
// delay-slot annul, memory back-pressure, and two saturating perf counters.
module ex_hazard_ctrl #(
  parameter int unsigned LOAD_USE_CYCLES = 1,
  parameter int unsigned STALL_CNT_W     = 32,
  parameter int unsigned FLUSH_CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  ex_hazard_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {RUN, LDUSE, MEMWAIT} state_t;

  state_t                 state;
  logic [2:0]             cnt;
  logic                   ret_ldu;
  logic [STALL_CNT_W-1:0] stall_cnt;
  logic [FLUSH_CNT_W-1:0] redir_cnt;

  logic match_rs1, match_rs2, hz, redirect, untaken_annul, in_ldu;
  logic hold_if, hold_id, hold_ex, kill_if, kill_id, take_pc;

  // Hazard detection and event decode for the instruction pair in ID/EX.
  always_comb begin
    match_rs1     = (bus.id_rs1 == bus.ex_rd) ||
                    (bus.ex_regWriteDouble && bus.id_rs1 == {bus.ex_rd[4:1], 1'b1});
    match_rs2     = (bus.id_rs2 == bus.ex_rd) ||
                    (bus.ex_regWriteDouble && bus.id_rs2 == {bus.ex_rd[4:1], 1'b1});
    hz            = bus.ex_valid && bus.ex_is_load && bus.ex_regWrite && bus.id_valid &&
                    (bus.ex_rd != 5'd0) &&
                    ((bus.id_uses_rs1 && match_rs1) || (bus.id_uses_rs2 && match_rs2));
    redirect      = bus.ex_valid && bus.ex_mux_sel;
    untaken_annul = bus.ex_valid && bus.ex_annul && !bus.ex_mux_sel;
    // A memory wait entered from LDUSE resumes the bubble sequence.
    in_ldu        = (state == LDUSE) || (state == MEMWAIT && ret_ldu);
  end

  // Combinational stall/kill/select in priority order; all quiet under reset.
  always_comb begin
    hold_if = 1'b0;
    hold_id = 1'b0;
    hold_ex = 1'b0;
    kill_if = 1'b0;
    kill_id = 1'b0;
    take_pc = 1'b0;
    if (!reset) begin
      if (!bus.mem_ready) begin
        hold_if = 1'b1;
        hold_id = 1'b1;
        hold_ex = 1'b1;
      end else if (in_ldu) begin
        hold_if = 1'b1;
        hold_id = 1'b1;
        kill_id = 1'b1;
      end else if (redirect) begin
        take_pc = 1'b1;
        kill_if = 1'b1;
        kill_id = bus.ex_annul;
      end else if (untaken_annul) begin
        kill_id = 1'b1;
      end else if (hz) begin
        hold_if = 1'b1;
        hold_id = 1'b1;
        kill_id = 1'b1;
      end
    end
  end

  assign bus.if_stall       = hold_if;
  assign bus.id_stall       = hold_id;
  assign bus.ex_stall       = hold_ex;
  assign bus.if_kill        = kill_if;
  assign bus.id_kill        = kill_id;
  assign bus.pc_sel         = take_pc;
  assign bus.stall_cycles   = stall_cnt;
  assign bus.redirect_count = redir_cnt;

  // Sequencer: bubble count-down, frozen across memory waits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      cnt     <= '0;
      ret_ldu <= 1'b0;
    end else if (!bus.mem_ready) begin
      state   <= MEMWAIT;
      // Keep the LDUSE return across back-to-back wait cycles, otherwise a
      // multi-cycle wait would drop the remaining bubbles.
      ret_ldu <= in_ldu;
    end else if (in_ldu) begin
      ret_ldu <= 1'b0;
      if (cnt > 3'd1) begin
        cnt   <= cnt - 3'd1;
        state <= LDUSE;
      end else begin
        state <= RUN;
      end
    end else begin
      ret_ldu <= 1'b0;
      if (!redirect && !untaken_annul && hz && LOAD_USE_CYCLES > 1) begin
        cnt   <= 3'(LOAD_USE_CYCLES - 1);
        state <= LDUSE;
      end else begin
        state <= RUN;
      end
    end
  end

  // Saturating performance counters; clear wins over increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      redir_cnt <= '0;
    end else if (bus.perf_clr) begin
      stall_cnt <= '0;
      redir_cnt <= '0;
    end else begin
      if (hold_id && stall_cnt != '1) stall_cnt <= stall_cnt + STALL_CNT_W'(1);
      if (take_pc && redir_cnt != '1) redir_cnt <= redir_cnt + FLUSH_CNT_W'(1);
    end
  end

endmodule
